change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Consumer end of the change/deposit interface of the vending-machine datapath unit.
- On a deposit strobe, latches the change amount in sen and decomposes it greedily into coins, largest denomination first.
- Issues one coin request at a time to the coin hopper over a valid/ack handshake.
- Tracks per-denomination coin stock and reports any shortfall it cannot pay out to the control unit.

Parameters:
- D0, 100, value of denomination 0 in sen (largest)
- D1, 50, value of denomination 1 in sen
- D2, 20, value of denomination 2 in sen
- D3, 10, value of denomination 3 in sen
- D4, 5, value of denomination 4 in sen (smallest); D0>D1>D2>D3>D4>0 required
- STOCK_W, 8, width of each stock counter
- INIT_STOCK, 20, stock loaded into every counter at reset
- ACK_TIMEOUT, 15, cycles coin_valid may stay high without coin_ack before a fault is declared

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- change  input  13  change amount in sen; sampled only when deposit=1
- deposit  input  1  one-cycle strobe: item dropped, pay out change
- coin_ack  input  1  hopper has ejected the requested coin; one-cycle pulse
- refill  input  1  one-cycle strobe: add refill_cnt coins to stock[refill_sel]
- refill_sel  input  3  denomination index 0..4; values 5..7 are ignored
- refill_cnt  input  STOCK_W  number of coins added
- coin_valid  output  1  coin request to hopper is pending
- coin_sel  output  3  denomination index of the pending request
- busy  output  1  payout in progress
- done  output  1  one-cycle pulse at payout end
- short_flag  output  1  high with done when change was not fully paid
- short_amt  output  13  unpaid remainder in sen; held until the next accepted deposit
- stock_empty  output  5  bit i = (stock[i]==0), combinational from the counters

Behaviour:
- Synchronous reset:
  - all outputs 0, remaining=0, timeout counter=0, state=IDLE
  - every stock[i]=INIT_STOCK
  - reset asserted mid-payout aborts the payout immediately; no done pulse is generated
- IDLE:
  - deposit=1 at edge k: remaining<=change, busy<=1, short_flag<=0, short_amt<=0, state<=SELECT
- SELECT (combinational choice of idx, then registered):
  - idx = lowest i such that D_i <= remaining and stock[i] > 0
  - If remaining==0: done<=1, busy<=0, state<=IDLE.
  - Else if idx exists: coin_sel<=idx, coin_valid<=1, timeout counter<=0, state<=WAIT.
  - Else (shortfall): done<=1, short_flag<=1, short_amt<=remaining, busy<=0, state<=IDLE.
- WAIT:
  - coin_valid and coin_sel are held stable until ack or timeout.
  - coin_ack=1: coin_valid<=0, remaining<=remaining-D[coin_sel], stock[coin_sel] decrements by 1, state<=SELECT.
  - Else the timeout counter increments. When it reaches ACK_TIMEOUT: coin_valid<=0, done<=1, short_flag<=1, short_amt<=remaining (this coin is not counted), busy<=0, state<=IDLE.
- Latency and coin pacing:
  - deposit at edge k -> coin_valid is first high after edge k+1.
  - change=0 -> done pulse after edge k+1, no coins issued.
  - coin_valid is low for exactly one cycle between consecutive coins.
  - Minimum spacing is 2 cycles per coin.
- Ignored inputs:
  - deposit while busy=1 is ignored; change is not resampled.
  - coin_ack while coin_valid=0 is ignored.
- Arithmetic rules:
  - remaining is 13 bits and never underflows, because a coin is chosen only if D_i <= remaining.
  - change values that are not a multiple of D4 always end in a shortfall of remaining mod D4 or more.
- Stock counters:
  - refill saturates at 2^STOCK_W-1.
  - Refill and decrement on the same index in the same cycle: result = sat(stock + refill_cnt - 1).
  - Refill on a different index proceeds independently.
  - Refill takes effect for the next SELECT decision.
- done and short_flag are 1-cycle pulses. short_amt persists.

Test Plan:
- Reset, then deposit change=185 with ack returned 1 cycle after each valid -> coin_sel sequence 0,1,2,3,4, then done=1, short_flag=0; stock[0..4]=19, busy low after done.
- Deposit change=0 -> no coin_valid; done pulse 2 cycles after deposit; short_flag=0.
- Set stock[0]=0 (reset with INIT_STOCK=0 variant, or drain), refill indices 1..4 to 20, change=200 -> four coin_sel=1 requests, done, no shortfall, stock_empty[0]=1.
- change=3 -> no coins; done with short_flag=1, short_amt=3. Then change=107 -> coins 0,4, then short_flag=1, short_amt=2.
- change=50, hopper never acks -> coin_valid high for ACK_TIMEOUT cycles then low; done, short_flag=1, short_amt=50; stock[1] unchanged.
- Second deposit (change=500) during a payout -> ignored. Refill idx 0 with refill_cnt=5 in the same cycle as an ack on idx 0 -> stock[0]=prev+4. Reset mid-WAIT -> coin_valid=0, busy=0, all stocks=INIT_STOCK, no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: greedy coin decomposition of a deposited change amount,
// one-at-a-time hopper handshake with ack timeout, per-denomination stock.
module change_dispenser #(
  parameter int unsigned D0          = 100,
  parameter int unsigned D1          = 50,
  parameter int unsigned D2          = 20,
  parameter int unsigned D3          = 10,
  parameter int unsigned D4          = 5,
  parameter int unsigned STOCK_W     = 8,
  parameter int unsigned INIT_STOCK  = 20,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [12:0]        change,
  input  logic               deposit,
  input  logic               coin_ack,
  input  logic               refill,
  input  logic [2:0]         refill_sel,
  input  logic [STOCK_W-1:0] refill_cnt,
  output logic               coin_valid,
  output logic [2:0]         coin_sel,
  output logic               busy,
  output logic               done,
  output logic               short_flag,
  output logic [12:0]        short_amt,
  output logic [4:0]         stock_empty
);

  localparam int unsigned AMT_W = 13;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_DEN = 5;
  localparam int unsigned SUM_W = STOCK_W + 1;
  localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               coin_valid_q, coin_valid_d;
  logic [SEL_W-1:0]   coin_sel_q, coin_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               short_flag_q, short_flag_d;
  logic [AMT_W-1:0]   short_amt_q, short_amt_d;
  logic [STOCK_W-1:0] stock_q [N_DEN];
  logic [STOCK_W-1:0] stock_d [N_DEN];

  logic               pick_ok;
  logic [SEL_W-1:0]   pick_idx;
  logic               dec_en;

  // Denomination value lookup by index; out-of-range indices never get picked.
  function automatic logic [AMT_W-1:0] denom(input logic [SEL_W-1:0] idx);
    case (idx)
      3'd0:    denom = AMT_W'(D0);
      3'd1:    denom = AMT_W'(D1);
      3'd2:    denom = AMT_W'(D2);
      3'd3:    denom = AMT_W'(D3);
      3'd4:    denom = AMT_W'(D4);
      default: denom = '0;
    endcase
  endfunction

  // Greedy pick: scan smallest to largest so the largest fitting, stocked coin wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int i = int'(N_DEN) - 1; i >= 0; i--) begin
      if ((denom(SEL_W'(i)) <= remaining_q) && (stock_q[i] != '0)) begin
        pick_ok  = 1'b1;
        pick_idx = SEL_W'(i);
      end
    end
  end

  // Payout FSM next-state and registered-output values.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    to_cnt_d     = to_cnt_q;
    coin_valid_d = coin_valid_q;
    coin_sel_d   = coin_sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    short_flag_d = 1'b0;
    short_amt_d  = short_amt_q;
    dec_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (deposit) begin
          remaining_d = change;
          busy_d      = 1'b1;
          short_amt_d = '0;
          state_d     = S_SELECT;
        end
      end

      S_SELECT: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (pick_ok) begin
          coin_sel_d   = pick_idx;
          coin_valid_d = 1'b1;
          to_cnt_d     = '0;
          state_d      = S_WAIT;
        end else begin
          done_d       = 1'b1;
          short_flag_d = 1'b1;
          short_amt_d  = remaining_q;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end

      S_WAIT: begin
        if (coin_ack) begin
          coin_valid_d = 1'b0;
          remaining_d  = remaining_q - denom(coin_sel_q);
          dec_en       = 1'b1;
          state_d      = S_SELECT;
        end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          // Hopper stuck: abandon the pending coin and report what is still owed.
          to_cnt_d     = TO_W'(ACK_TIMEOUT);
          coin_valid_d = 1'b0;
          done_d       = 1'b1;
          short_flag_d = 1'b1;
          short_amt_d  = remaining_q;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Stock update: saturating refill combined with the ack decrement.
  always_comb begin
    logic [SUM_W-1:0] add;
    logic [SUM_W-1:0] sub;
    logic [SUM_W-1:0] sum;
    add = '0;
    sub = '0;
    sum = '0;
    for (int i = 0; i < int'(N_DEN); i++) begin
      add = (refill && (refill_sel == SEL_W'(i))) ? {1'b0, refill_cnt} : '0;
      sub = (dec_en && (coin_sel_q == SEL_W'(i))) ? SUM_W'(1) : '0;
      sum = {1'b0, stock_q[i]} + add - sub;
      stock_d[i] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_DEN); i++) begin
      stock_empty[i] = (stock_q[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      to_cnt_q     <= '0;
      coin_valid_q <= 1'b0;
      coin_sel_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_flag_q <= 1'b0;
      short_amt_q  <= '0;
      for (int i = 0; i < int'(N_DEN); i++) begin
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      to_cnt_q     <= to_cnt_d;
      coin_valid_q <= coin_valid_d;
      coin_sel_q   <= coin_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      short_flag_q <= short_flag_d;
      short_amt_q  <= short_amt_d;
      for (int i = 0; i < int'(N_DEN); i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_sel   = coin_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short_flag = short_flag_q;
  assign short_amt  = short_amt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, shortfall, timeout, refill, reset.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] change;
  logic        deposit;
  logic        coin_ack;
  logic        refill;
  logic [2:0]  refill_sel;
  logic [7:0]  refill_cnt;
  logic        coin_valid;
  logic [2:0]  coin_sel;
  logic        busy;
  logic        done;
  logic        short_flag;
  logic [12:0] short_amt;
  logic [4:0]  stock_empty;

  int checks = 0;
  int passed = 0;

  // Observations from the hopper model
  int  n_coins, n_sel0, code, valid_cycles, done_cyc;
  bit  got_done, done_short, busy_at_done;
  int  done_amt;

  change_dispenser dut (
    .clk(clk), .rst(rst), .change(change), .deposit(deposit), .coin_ack(coin_ack),
    .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .busy(busy), .done(done),
    .short_flag(short_flag), .short_amt(short_amt), .stock_empty(stock_empty)
  );

  always #5 clk = ~clk;

  task automatic do_deposit(input int amt);
    @(negedge clk);
    deposit = 1'b1;
    change  = 13'(amt);
    @(negedge clk);
    deposit = 1'b0;
  endtask

  task automatic do_refill(input int sel, input int cnt);
    @(negedge clk);
    refill     = 1'b1;
    refill_sel = 3'(sel);
    refill_cnt = 8'(cnt);
    @(negedge clk);
    refill = 1'b0;
  endtask

  // Hopper model: acks each request in the first cycle it is seen (if enabled).
  task automatic serve(input int budget, input bit ack_en);
    bit prev_valid;
    prev_valid = 1'b0;
    n_coins = 0; n_sel0 = 0; code = 0; valid_cycles = 0; done_cyc = -1;
    got_done = 1'b0; done_short = 1'b0; done_amt = -1; busy_at_done = 1'b1;
    for (int c = 0; c < budget && !got_done; c++) begin
      @(negedge clk);
      coin_ack = 1'b0;
      if (done) begin
        got_done = 1'b1; done_short = short_flag; done_amt = int'(short_amt);
        busy_at_done = busy; done_cyc = c;
      end
      if (coin_valid) begin
        valid_cycles++;
        if (!prev_valid) begin
          n_coins++;
          if (coin_sel == 3'd0) n_sel0++;
          code = code * 10 + int'(coin_sel) + 1;
        end
        if (ack_en) coin_ack = 1'b1;
      end
      prev_valid = coin_valid;
    end
    coin_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({coin_valid, coin_sel, busy, done, short_flag, short_amt} !== 20'd0)
      $display("FAIL reset_outputs: got %h want 0", {coin_valid, coin_sel, busy, done, short_flag, short_amt});
    else passed++;
    checks++;
    if (stock_empty !== 5'b00000) $display("FAIL reset_empty: got %b want 00000", stock_empty);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.stock_q[i] !== 8'd20) $display("FAIL reset_stock%0d: got %0d want 20", i, dut.stock_q[i]);
      else passed++;
    end
  endtask

  task automatic test_greedy_185;
    do_deposit(185);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_deposit: got %b want 1", busy);
    else passed++;
    serve(100, 1'b1);
    checks++;
    if (code !== 12345) $display("FAIL seq_185: got %0d want 12345", code);
    else passed++;
    checks++;
    if (got_done !== 1'b1 || done_short !== 1'b0 || busy_at_done !== 1'b0)
      $display("FAIL done_185: got done=%b short=%b busy=%b want 1 0 0", got_done, done_short, busy_at_done);
    else passed++;
    // one-cycle gap per coin: valid 1 cycle, low 1 cycle; 5 coins then done
    checks++;
    if (done_cyc !== 10) $display("FAIL pacing_185: got done at %0d want 10", done_cyc);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL done_pulse_185: got %b want 0", done);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.stock_q[i] !== 8'd19) $display("FAIL stock_185_%0d: got %0d want 19", i, dut.stock_q[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_change;
    do_deposit(0);
    serve(10, 1'b1);
    checks++;
    if (n_coins !== 0 || got_done !== 1'b1 || done_short !== 1'b0 || done_cyc !== 0)
      $display("FAIL zero_change: got coins=%0d done=%b short=%b cyc=%0d want 0 1 0 0",
               n_coins, got_done, done_short, done_cyc);
    else passed++;
  endtask

  task automatic test_drain_refill;
    do_deposit(1900);
    serve(100, 1'b1);
    checks++;
    if (n_coins !== 19 || n_sel0 !== 19 || done_short !== 1'b0 || got_done !== 1'b1)
      $display("FAIL drain_1900: got coins=%0d sel0=%0d short=%b want 19 19 0", n_coins, n_sel0, done_short);
    else passed++;
    checks++;
    if (stock_empty !== 5'b00001) $display("FAIL drain_empty: got %b want 00001", stock_empty);
    else passed++;
    for (int i = 1; i < 5; i++) do_refill(i, 1);
    do_refill(5, 9);
    checks++;
    if (dut.stock_q[1] !== 8'd20 || dut.stock_q[4] !== 8'd20 || dut.stock_q[0] !== 8'd0)
      $display("FAIL refill_1_4: got %0d %0d %0d want 0 20 20", dut.stock_q[0], dut.stock_q[1], dut.stock_q[4]);
    else passed++;
    do_deposit(200);
    serve(50, 1'b1);
    checks++;
    if (code !== 2222 || done_short !== 1'b0 || got_done !== 1'b1)
      $display("FAIL seq_200: got %0d short=%b want 2222 0", code, done_short);
    else passed++;
    checks++;
    if (dut.stock_q[1] !== 8'd16 || stock_empty[0] !== 1'b1)
      $display("FAIL stock_200: got %0d empty0=%b want 16 1", dut.stock_q[1], stock_empty[0]);
    else passed++;
  endtask

  task automatic test_shortfall;
    do_deposit(3);
    serve(10, 1'b1);
    checks++;
    if (n_coins !== 0 || done_short !== 1'b1 || done_amt !== 3)
      $display("FAIL short_3: got coins=%0d short=%b amt=%0d want 0 1 3", n_coins, done_short, done_amt);
    else passed++;
    do_refill(0, 5);
    do_deposit(107);
    serve(50, 1'b1);
    checks++;
    if (code !== 15 || done_short !== 1'b1 || done_amt !== 2)
      $display("FAIL short_107: got seq=%0d short=%b amt=%0d want 15 1 2", code, done_short, done_amt);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (short_amt !== 13'd2 || short_flag !== 1'b0)
      $display("FAIL short_hold: got amt=%0d flag=%b want 2 0", short_amt, short_flag);
    else passed++;
    checks++;
    if (dut.stock_q[0] !== 8'd4 || dut.stock_q[4] !== 8'd19)
      $display("FAIL stock_107: got %0d %0d want 4 19", dut.stock_q[0], dut.stock_q[4]);
    else passed++;
  endtask

  task automatic test_timeout;
    do_deposit(50);
    serve(40, 1'b0);
    checks++;
    if (valid_cycles !== 15 || n_coins !== 1 || code !== 2)
      $display("FAIL timeout_valid: got cycles=%0d coins=%0d seq=%0d want 15 1 2", valid_cycles, n_coins, code);
    else passed++;
    checks++;
    if (got_done !== 1'b1 || done_short !== 1'b1 || done_amt !== 50 || coin_valid !== 1'b0)
      $display("FAIL timeout_done: got done=%b short=%b amt=%0d valid=%b want 1 1 50 0",
               got_done, done_short, done_amt, coin_valid);
    else passed++;
    checks++;
    if (dut.stock_q[1] !== 8'd16) $display("FAIL timeout_stock: got %0d want 16", dut.stock_q[1]);
    else passed++;
  endtask

  task automatic test_back_to_back;
    do_deposit(100);
    checks++;
    if (short_amt !== 13'd0) $display("FAIL amt_clear: got %0d want 0", short_amt);
    else passed++;
    deposit = 1'b1;
    change  = 13'd500;
    @(negedge clk);
    deposit = 1'b0;
    checks++;
    if (coin_valid !== 1'b1 || coin_sel !== 3'd0)
      $display("FAIL b2b_first: got valid=%b sel=%0d want 1 0", coin_valid, coin_sel);
    else passed++;
    coin_ack = 1'b1; refill = 1'b1; refill_sel = 3'd0; refill_cnt = 8'd5;
    @(negedge clk);
    coin_ack = 1'b0; refill = 1'b0;
    checks++;
    if (dut.stock_q[0] !== 8'd8) $display("FAIL refill_and_dec: got %0d want 8", dut.stock_q[0]);
    else passed++;
    serve(20, 1'b1);
    checks++;
    if (n_coins !== 0 || got_done !== 1'b1 || done_short !== 1'b0 || done_cyc !== 0)
      $display("FAIL b2b_done: got coins=%0d done=%b short=%b cyc=%0d want 0 1 0 0",
               n_coins, got_done, done_short, done_cyc);
    else passed++;
    serve(5, 1'b1);
    checks++;
    if (n_coins !== 0 || got_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL deposit_ignored: got coins=%0d done=%b busy=%b want 0 0 0", n_coins, got_done, busy);
    else passed++;
    @(negedge clk);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.stock_q[0] !== 8'd8 || dut.stock_q[1] !== 8'd16 || coin_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_ack: got %0d %0d valid=%b busy=%b want 8 16 0 0",
               dut.stock_q[0], dut.stock_q[1], coin_valid, busy);
    else passed++;
    do_refill(2, 255);
    checks++;
    if (dut.stock_q[2] !== 8'd255) $display("FAIL refill_sat: got %0d want 255", dut.stock_q[2]);
    else passed++;
  endtask

  task automatic test_reset_mid_wait;
    bit saw_done;
    do_deposit(50);
    @(negedge clk);
    checks++;
    if (coin_valid !== 1'b1 || coin_sel !== 3'd1)
      $display("FAIL mid_wait_valid: got valid=%b sel=%0d want 1 1", coin_valid, coin_sel);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || short_amt !== 13'd0)
      $display("FAIL mid_reset_out: got valid=%b busy=%b done=%b amt=%0d want 0 0 0 0",
               coin_valid, busy, done, short_amt);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.stock_q[i] !== 8'd20) $display("FAIL mid_reset_stock%0d: got %0d want 20", i, dut.stock_q[i]);
      else passed++;
    end
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || coin_valid) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) $display("FAIL mid_reset_quiet: got %b want 0", saw_done);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; change = '0; deposit = 1'b0; coin_ack = 1'b0;
    refill = 1'b0; refill_sel = '0; refill_cnt = '0;
    test_reset();
    test_greedy_185();
    test_zero_change();
    test_drain_refill();
    test_shortfall();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
